// File: rtl/lms_sequencer_if.sv
// rtl/lms_sequencer_if.sv - strobe/handshake bundle between lms_sequencer and the LMS datapath
// Optional LMS_SEQ_FREEZE_EN adds freeze_in.
interface lms_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              ready_in;
`ifdef LMS_SEQ_FREEZE_EN
  logic              freeze_in;
`endif
  logic              busy_out;
  logic              wr_sample_out;
  logic [ADDR_W-1:0] head_out;
  logic [ADDR_W-1:0] tap_addr_out;
  logic [ADDR_W-1:0] sample_addr_out;
  logic              mul_sel_out;
  logic              acc_clr_out;
  logic              acc_en_out;
  logic              err_latch_out;
  logic              coef_we_out;
  logic [ADDR_W-1:0] coef_waddr_out;
  logic              done_out;
  logic              overrun_out;

  modport master (
`ifdef LMS_SEQ_FREEZE_EN
    input  freeze_in,
`endif
    input  ready_in,
    output busy_out, wr_sample_out, head_out, tap_addr_out, sample_addr_out,
    output mul_sel_out, acc_clr_out, acc_en_out, err_latch_out,
    output coef_we_out, coef_waddr_out, done_out, overrun_out
  );

  modport slave (
`ifdef LMS_SEQ_FREEZE_EN
    output freeze_in,
`endif
    output ready_in,
    input  busy_out, wr_sample_out, head_out, tap_addr_out, sample_addr_out,
    input  mul_sel_out, acc_clr_out, acc_en_out, err_latch_out,
    input  coef_we_out, coef_waddr_out, done_out, overrun_out
  );
endinterface

// File: rtl/lms_sequencer.sv
// rtl/lms_sequencer.sv - per-sample schedule sequencer for the time-multiplexed LMS FIR
// Optional LMS_SEQ_FREEZE_EN: freeze_in skips the coefficient update sweep.
module lms_sequencer #(
  parameter int TAPS    = 31,
  parameter int ADDR_W  = 5,
  parameter int MUL_LAT = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  lms_sequencer_if.master bus
);
  localparam int                CNT_W      = $clog2(MUL_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FILTER, DRAIN, ERROR, UPDATE, UDRAIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  drain_cnt;
  logic [MUL_LAT-1:0] acc_pipe;
  logic [MUL_LAT-1:0] we_pipe;
  logic [ADDR_W-1:0] waddr_pipe [MUL_LAT];
  logic              freeze;

`ifdef LMS_SEQ_FREEZE_EN
  assign freeze = bus.freeze_in;
`else
  assign freeze = 1'b0;
`endif

  // Delay pipes model the multiplier latency; their last stages are the outputs.
  assign bus.acc_en_out     = acc_pipe[MUL_LAT-1];
  assign bus.coef_we_out    = we_pipe[MUL_LAT-1];
  assign bus.coef_waddr_out = waddr_pipe[MUL_LAT-1];

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] v);
    return (v == '0) ? LAST_IDX : v - 1'b1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      drain_cnt           <= '0;
      acc_pipe            <= '0;
      we_pipe             <= '0;
      for (int i = 0; i < MUL_LAT; i++) waddr_pipe[i] <= '0;
      bus.busy_out        <= 1'b0;
      bus.wr_sample_out   <= 1'b0;
      bus.head_out        <= '0;
      bus.tap_addr_out    <= '0;
      bus.sample_addr_out <= '0;
      bus.mul_sel_out     <= 1'b0;
      bus.acc_clr_out     <= 1'b0;
      bus.err_latch_out   <= 1'b0;
      bus.done_out        <= 1'b0;
      bus.overrun_out     <= 1'b0;
    end else begin
      bus.wr_sample_out <= 1'b0;
      bus.acc_clr_out   <= 1'b0;
      bus.err_latch_out <= 1'b0;
      bus.done_out      <= 1'b0;
      bus.overrun_out   <= bus.ready_in && bus.busy_out;

      acc_pipe[0]   <= (state == FILTER);
      we_pipe[0]    <= (state == UPDATE);
      waddr_pipe[0] <= bus.tap_addr_out;
      for (int i = 1; i < MUL_LAT; i++) begin
        acc_pipe[i]   <= acc_pipe[i-1];
        we_pipe[i]    <= we_pipe[i-1];
        waddr_pipe[i] <= waddr_pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (bus.ready_in) begin
            state             <= LOAD;
            bus.busy_out      <= 1'b1;
            bus.wr_sample_out <= 1'b1;
            bus.acc_clr_out   <= 1'b1;
            bus.tap_addr_out  <= '0;
          end
        end
        LOAD: begin
          state               <= FILTER;
          bus.tap_addr_out    <= '0;
          bus.sample_addr_out <= bus.head_out;
          bus.mul_sel_out     <= 1'b0;
        end
        FILTER: begin
          if (bus.tap_addr_out == LAST_IDX) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            bus.tap_addr_out    <= bus.tap_addr_out + 1'b1;
            bus.sample_addr_out <= wrap_dec(bus.sample_addr_out);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state             <= ERROR;
            bus.err_latch_out <= 1'b1;
            bus.done_out      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ERROR: begin
          if (freeze) begin
            state        <= IDLE;
            bus.busy_out <= 1'b0;
            bus.head_out <= wrap_inc(bus.head_out);
          end else begin
            state               <= UPDATE;
            bus.tap_addr_out    <= '0;
            bus.sample_addr_out <= bus.head_out;
            bus.mul_sel_out     <= 1'b1;
          end
        end
        UPDATE: begin
          if (bus.tap_addr_out == LAST_IDX) begin
            state     <= UDRAIN;
            drain_cnt <= '0;
          end else begin
            bus.tap_addr_out    <= bus.tap_addr_out + 1'b1;
            bus.sample_addr_out <= wrap_dec(bus.sample_addr_out);
          end
        end
        UDRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state        <= IDLE;
            bus.busy_out <= 1'b0;
            bus.head_out <= wrap_inc(bus.head_out);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/lms_sequencer.md
# lms_sequencer

Control sequencer for the time-multiplexed LMS adaptive FIR in the noise-cancellation path. On each sample strobe it runs the whole per-sample schedule over one shared multiplier and one accumulator: write the sample, run the filter MAC sweep, capture the error, then run the coefficient-update sweep. It drives delay-line and coefficient addresses, the multiplier operand select and all datapath strobes. It finishes well inside the 128-clock sample period.

## Interface
Parameters:
- TAPS, 31: filter length; also the delay-line and coefficient memory depth.
- ADDR_W, 5: address width; must satisfy 2^ADDR_W >= TAPS.
- MUL_LAT, 2: shared multiplier pipeline latency in cycles; must be >= 1.

Ports:
- clk_in  in  1  system clock; the single clock.
- rst_in  in  1  synchronous, active-high reset.
- ready_in  in  1  one-cycle new-sample strobe.
- busy_out  out  1  high in every non-IDLE state.
- wr_sample_out  out  1  write the new sample into the delay line at head_out.
- head_out  out  ADDR_W  delay-line head pointer.
- tap_addr_out  out  ADDR_W  coefficient read index k.
- sample_addr_out  out  ADDR_W  delay-line read index, (head − k) mod TAPS.
- mul_sel_out  out  1  multiplier operand select: 0 = coef×sample, 1 = err×sample.
- acc_clr_out  out  1  clear the accumulator.
- acc_en_out  out  1  accumulate the multiplier output.
- err_latch_out  out  1  capture the error (desired − y).
- coef_we_out  out  1  coefficient write-back enable.
- coef_waddr_out  out  ADDR_W  write-back index; this is tap_addr_out delayed by MUL_LAT.
- done_out  out  1  one-cycle pulse; y is valid at the accumulator.
- overrun_out  out  1  one-cycle pulse; a sample was dropped.

## Operation
- States: IDLE → LOAD (1 cycle) → FILTER (TAPS cycles) → DRAIN (MUL_LAT cycles) → ERROR (1 cycle) → UPDATE (TAPS cycles) → UDRAIN (MUL_LAT cycles) → IDLE.
- IDLE: when ready_in = 1, go to LOAD.
- LOAD: wr_sample_out = 1 and acc_clr_out = 1. The index counter k is set to 0.
- FILTER: mul_sel_out = 0. tap_addr_out = k, with k counting 0..TAPS−1. sample_addr_out = head ≥ k ? head − k : head + TAPS − k.
- acc_en_out is the FILTER-issue flag delayed by MUL_LAT. It therefore asserts during the first MUL_LAT cycles of DRAIN as well.
- ERROR: err_latch_out = 1 and done_out = 1.
- UPDATE: mul_sel_out = 1. k sweeps 0..TAPS−1 again, and addresses are formed as in FILTER.
- coef_we_out is the UPDATE-issue flag delayed by MUL_LAT. coef_waddr_out is k delayed by MUL_LAT.
- Last UDRAIN cycle: head advances. head = (head == TAPS−1) ? 0 : head + 1.
- Overrun: ready_in while busy_out = 1 pulses overrun_out the next cycle. The sample is ignored and the schedule is unaffected. This includes ready_in on the final UDRAIN cycle.
- mul_sel_out holds its last value outside FILTER and UPDATE.
- All strobes are 0 outside the states and delay windows listed above.

## Timing
- Cycle n means n clocks after the edge that samples ready_in.
- LOAD runs at cycle 1.
- FILTER runs at cycles 2..TAPS+1.
- done_out fires at cycle TAPS+MUL_LAT+2 (cycle 35 with defaults).
- IDLE is re-entered at cycle 2·TAPS+2·MUL_LAT+3 (cycle 69 with defaults).
- Back-to-back ready_in is accepted from that cycle onward.
- All outputs are registered.
- Reset values: every output is 0; head = 0; k = 0; state = IDLE. The delay pipes for acc_en_out and coef_we_out are flushed.
- Reset mid-schedule aborts immediately. No further coef_we_out or acc_en_out pulses follow, even ones already in the delay pipe, and head returns to 0.
- Reset has priority over ready_in in the same cycle.

## Configuration
- LMS_SEQ_FREEZE_EN: when defined, adds the input freeze_in (1 bit), which freezes adaptation.
  - freeze_in is sampled in the ERROR cycle.
  - If freeze_in = 1, UPDATE and UDRAIN are skipped. ERROR goes directly to IDLE, head advances on the ERROR cycle, and no coef_we_out pulses occur.
  - IDLE is then re-entered at cycle TAPS+MUL_LAT+3.
- Undefined: the freeze_in port does not exist and every sample runs the full update.

## Test plan
- Single sample, defaults, head = 0 → wr_sample_out at cycle 1; tap_addr_out 0..30 over cycles 2..32; acc_en_out at cycles 4..34; done_out at cycle 35; coef_we_out at cycles 38..68 with coef_waddr_out 0..30; busy_out at cycles 1..68; head_out = 1 at cycle 69.
- Address wrap with head = 3 → sample_addr_out follows 3, 2, 1, 0, 30, 29, …, 4 during FILTER and again during UPDATE.
- Head wrap: 31 samples spaced 128 clocks apart → head_out goes 1..30, then 0, with no glitch.
- Overrun: second ready_in at cycle 20 and a third at cycle 68 → overrun_out pulses at cycles 21 and 69; schedule and head unchanged; ready_in at cycle 69 is accepted.
- Reset at cycle 40 → all outputs 0 at cycle 41; no coef_we_out afterwards; head_out = 0.
- With LMS_SEQ_FREEZE_EN and freeze_in = 1 → done_out at cycle 35; no coef_we_out; busy_out low at cycle 36; head_out increments.
